char_writer: RTL

Turns the byte stream from the UART receiver into writes to the character memory read by the VGA character generator. It sits between the UART receiver (upstream) and the character memory write port (downstream). It keeps a text cursor and places printable bytes at the cursor, advancing and wrapping it. It interprets CR, LF, BS and FF control codes and runs a full-screen clear sequence.

---
 rtl/char_writer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/char_writer.sv
// char_writer
//
// Turns the UART receive byte stream into character-memory writes for the
// VGA text display. Keeps a text cursor. Printable bytes are written at the
// cursor, which then advances and wraps. CR, LF, BS and FF are interpreted.
// A clear request blanks the whole screen, one write per cycle.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-low reset
//   rx_data     received byte, qualified by rx_strobe
//   rx_strobe   one-cycle pulse per received byte
//   clear       one-cycle screen-clear request (already synchronized)
//   char_addr   write address {row[4:0], col[6:0]}
//   char_data   write data
//   char_we     write enable, one cycle per write
//   cursor_col  current cursor column
//   cursor_row  current cursor row
//   busy        clear sequence in progress
//   dropped     one-cycle pulse when a received byte is discarded
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | decode bytes (pending byte first), accept clear requests
// CLEAR  | blank the screen in raster order, buffer one incoming byte

module char_writer #(
  parameter int          COLUMNS    = 80,
  parameter int          ROWS       = 30,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  input  logic        clear,
  output logic [11:0] char_addr,
  output logic [7:0]  char_data,
  output logic        char_we,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy,
  output logic        dropped
);

  localparam logic [6:0] COL_LAST = 7'(COLUMNS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic        pend_valid_q, pend_valid_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic [6:0]  clr_col_q, clr_col_d;
  logic [4:0]  clr_row_q, clr_row_d;
  logic [11:0] addr_d;
  logic [7:0]  data_d;
  logic        we_d;
  logic        busy_d;
  logic        dropped_d;

  logic        src_valid;
  logic [7:0]  src_byte;
  logic        start_clear;
  logic [4:0]  row_inc;
  logic [6:0]  clr_col_nxt;
  logic [4:0]  clr_row_nxt;

  assign row_inc = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;

  // Raster successor of the address written last cycle during CLEAR.
  always_comb begin
    clr_col_nxt = clr_col_q + 7'd1;
    clr_row_nxt = clr_row_q;
    if (clr_col_q == COL_LAST) begin
      clr_col_nxt = 7'd0;
      clr_row_nxt = clr_row_q + 5'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    clr_col_d    = clr_col_q;
    clr_row_d    = clr_row_q;
    addr_d       = char_addr;
    data_d       = char_data;
    we_d         = 1'b0;
    busy_d       = 1'b0;
    dropped_d    = 1'b0;
    src_valid    = 1'b0;
    src_byte     = pend_data_q;
    start_clear  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          // Clear wins; a simultaneous byte is parked, or lost if the
          // pending slot is already taken.
          start_clear = 1'b1;
          if (rx_strobe) begin
            if (pend_valid_q) begin
              dropped_d = 1'b1;
            end else begin
              pend_valid_d = 1'b1;
              pend_data_d  = rx_data;
            end
          end
        end else if (pend_valid_q) begin
          src_valid = 1'b1;
          src_byte  = pend_data_q;
          if (rx_strobe) begin
            pend_data_d = rx_data;
          end else begin
            pend_valid_d = 1'b0;
          end
        end else if (rx_strobe) begin
          src_valid = 1'b1;
          src_byte  = rx_data;
        end

        if (src_valid) begin
          if (src_byte >= 8'h20 && src_byte <= 8'h7E) begin
            we_d   = 1'b1;
            addr_d = {row_q, col_q};
            data_d = src_byte;
            if (col_q == COL_LAST) begin
              col_d = 7'd0;
              row_d = row_inc;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            case (src_byte)
              8'h0D: col_d = 7'd0;
              8'h0A: row_d = row_inc;
              8'h08: begin
                if (col_q != 7'd0) begin
                  col_d  = col_q - 7'd1;
                  we_d   = 1'b1;
                  addr_d = {row_q, col_q - 7'd1};
                  data_d = BLANK_CHAR;
                end
              end
              8'h0C:   start_clear = 1'b1;
              default: ;
            endcase
          end
        end

        if (start_clear) begin
          // First blank write goes out with the state change.
          state_d   = S_CLEAR;
          busy_d    = 1'b1;
          col_d     = 7'd0;
          row_d     = 5'd0;
          clr_col_d = 7'd0;
          clr_row_d = 5'd0;
          we_d      = 1'b1;
          addr_d    = 12'd0;
          data_d    = BLANK_CHAR;
        end
      end

      S_CLEAR: begin
        // busy stays high through the cycle that shows the last write,
        // while the state is already back in IDLE.
        busy_d    = 1'b1;
        clr_col_d = clr_col_nxt;
        clr_row_d = clr_row_nxt;
        we_d      = 1'b1;
        addr_d    = {clr_row_nxt, clr_col_nxt};
        data_d    = BLANK_CHAR;
        if (clr_col_nxt == COL_LAST && clr_row_nxt == ROW_LAST) begin
          state_d = S_IDLE;
        end
        if (rx_strobe) begin
          if (pend_valid_q) begin
            dropped_d = 1'b1;
          end else begin
            pend_valid_d = 1'b1;
            pend_data_d  = rx_data;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      col_q        <= 7'd0;
      row_q        <= 5'd0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= 8'd0;
      clr_col_q    <= 7'd0;
      clr_row_q    <= 5'd0;
      char_addr    <= 12'd0;
      char_data    <= 8'd0;
      char_we      <= 1'b0;
      busy         <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      clr_col_q    <= clr_col_d;
      clr_row_q    <= clr_row_d;
      char_addr    <= addr_d;
      char_data    <= data_d;
      char_we      <= we_d;
      busy         <= busy_d;
      dropped      <= dropped_d;
    end
  end

  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule
